cnn16_prog_loader: RTL and testbench
====================================

# cnn16_prog_loader

Byte-stream program loader that sits directly upstream of the CNN-16 RAM/CPU pair. It receives a framed program image one byte at a time over a valid/ready handshake, assembles big-endian 16-bit words and writes them to consecutive RAM addresses. It drives the RAM-side select/write-enable/address/data mux inputs while loading, then releases the RAM to the CPU once the frame checksum is verified.

## Interface
- ADDR_W, 12, RAM address width; addresses wrap modulo 2^ADDR_W
- SYNC_BYTE, 8'hA5, frame start marker
- clkn  in  1  clock, rising-edge
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle; transfer when rx_valid && rx_ready
- mem_sel  out  1  1 = loader owns RAM (drives sel_in), 0 = CPU owns RAM
- mem_we  out  1  RAM write strobe, one-cycle pulse per word
- mem_adr  out  ADDR_W  RAM write address
- mem_data  out  16  RAM write data
- load_done  out  1  level: last frame loaded and checksum matched
- load_err  out  1  level: last frame aborted (bad count or checksum)
- words_written  out  ADDR_W+1  words written in current/last frame

## Operation
- Frame after SYNC_BYTE: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words as HI/LO byte pairs, then one checksum byte.
- Start address = {ADDR_HI,ADDR_LO}[ADDR_W-1:0]; upper bits ignored. CNT is 16-bit unsigned.
- Checksum = XOR of every byte after SYNC_BYTE up to and including the last data byte; frame is good when it equals the checksum byte.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERR.
- IDLE/DONE/ERR: accept and discard bytes; SYNC_BYTE -> ADDR_HI, clears load_done, load_err, words_written and checksum, sets mem_sel=1.
- ADDR_HI -> ADDR_LO -> CNT_HI -> CNT_LO, one accepted byte each.
- CNT_LO: CNT = 0 -> CHECK; CNT > 2^ADDR_W -> ERR immediately; else -> DATA_HI.
- DATA_HI -> DATA_LO -> WRITE. WRITE: mem_we=1 with mem_adr/mem_data valid, address += 1 (wraps 0xFFF -> 0x000), words_written += 1; -> DATA_HI if words remain, else CHECK.
- CHECK: next accepted byte compared; match -> DONE (load_done=1, mem_sel=0); mismatch -> ERR (load_err=1, mem_sel stays 1 so CPU remains held off a partial image).
- Non-sync bytes in DATA_*/header states are data, never resynchronise.

## Timing
- Reset values: rx_ready=1, mem_sel=0, mem_we=0, mem_adr=0, mem_data=0, load_done=0, load_err=0, words_written=0, state IDLE.
- rx_ready=1 in every state except WRITE (0 for exactly one cycle).
- mem_we asserts the cycle after the DATA_LO byte is accepted; address/data registered and stable while mem_we=1 and held afterwards.
- Minimum frame throughput: 3 cycles per word (2 bytes + WRITE); rx_valid gaps only stall, never alter data.
- mem_sel rises the cycle after SYNC_BYTE is accepted, falls the cycle after a matching checksum is accepted.
- load_done/load_err are mutually exclusive, registered, change only on the transitions above.
- rstn assertion mid-frame: immediate return to reset values, including mem_we=0 even if in WRITE; partial RAM contents left as written.

## Structure
- Shared package cnn16_pkg: loader state enum, SYNC_BYTE default, ADDR_W, word width 16.
- Single module; no sub-module needed (word assembly and XOR checksum are a few registers each).

## Test plan
- Sync A5, addr 00 10, cnt 00 03, words 1234 ABCD 0F0F, correct checksum -> writes 0x010=1234, 0x011=ABCD, 0x012=0F0F, load_done=1, mem_sel=0, words_written=3.
- Same frame with checksum byte flipped -> three writes occur, load_err=1, load_done=0, mem_sel stays 1; subsequent good frame clears load_err and completes.
- Addr 0F FF, cnt 00 02 -> writes at 0xFFF then 0x000.
- Cnt 00 00 with checksum 0x0F^0xFF (addr 0F FF) -> no mem_we, load_done=1; cnt 10 01 -> load_err=1 straight after CNT_LO.
- Random rx_valid gaps and rx_valid held during WRITE -> byte not lost, rx_ready=0 exactly one cycle per word, RAM image identical.
- rstn pulsed after second word of 5-word frame -> all outputs at reset values, state IDLE, next A5 frame loads correctly.

Source files
------------

// File: rtl/cnn16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn16_pkg
// Purpose  : Shared loader types and defaults for the CNN-16 program loader.
// Revision : 1.0 - initial release
// ============================================================================
package cnn16_pkg;

  localparam int          LOADER_ADDR_W    = 12;
  localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;
  localparam int          WORD_W           = 16;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_CNT_HI  = 4'd3,
    ST_CNT_LO  = 4'd4,
    ST_DATA_HI = 4'd5,
    ST_DATA_LO = 4'd6,
    ST_WRITE   = 4'd7,
    ST_CHECK   = 4'd8,
    ST_DONE    = 4'd9,
    ST_ERR     = 4'd10
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/cnn16_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : cnn16_prog_loader
// Purpose  : Framed byte-stream loader writing big-endian 16-bit words to RAM.
// Revision : 1.0 - initial release
// ============================================================================
module cnn16_prog_loader
  import cnn16_pkg::*;
#(
  parameter int         ADDR_W    = LOADER_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = LOADER_SYNC_BYTE
) (
  input  logic                clkn,
  input  logic                rstn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                mem_sel,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_adr,
  output logic [WORD_W-1:0]   mem_data,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDR_W:0]     words_written
);

  localparam logic [16:0] c_max_cnt = 17'(1) << ADDR_W;

  loader_state_t       r_state, w_state_nxt;
  logic [7:0]          r_addr_hi, r_cnt_hi, r_data_hi, r_csum;
  logic [ADDR_W-1:0]   r_ptr, r_mem_adr;
  logic [15:0]         r_remaining;
  logic [WORD_W-1:0]   r_mem_data;
  logic [ADDR_W:0]     r_words;
  logic                r_we, r_sel, r_done, r_err;

  logic                w_xfer, w_is_sync, w_cnt_zero, w_cnt_big, w_csum_ok;
  logic [16:0]         w_cnt_full;

  assign rx_ready   = (r_state != ST_WRITE);
  assign w_xfer     = rx_valid & rx_ready;
  assign w_is_sync  = (rx_data == SYNC_BYTE);
  assign w_cnt_full = {1'b0, r_cnt_hi, rx_data};
  assign w_cnt_zero = (w_cnt_full == 17'd0);
  assign w_cnt_big  = (w_cnt_full > c_max_cnt);
  assign w_csum_ok  = (rx_data == r_csum);

  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (w_xfer && w_is_sync) w_state_nxt = ST_ADDR_HI;
      ST_ADDR_HI: if (w_xfer) w_state_nxt = ST_ADDR_LO;
      ST_ADDR_LO: if (w_xfer) w_state_nxt = ST_CNT_HI;
      ST_CNT_HI:  if (w_xfer) w_state_nxt = ST_CNT_LO;
      ST_CNT_LO: begin
        if (w_xfer) begin
          if (w_cnt_zero)     w_state_nxt = ST_CHECK;
          else if (w_cnt_big) w_state_nxt = ST_ERR;
          else                w_state_nxt = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (w_xfer) w_state_nxt = ST_DATA_LO;
      ST_DATA_LO: if (w_xfer) w_state_nxt = ST_WRITE;
      ST_WRITE:   w_state_nxt = (r_remaining == 16'd1) ? ST_CHECK : ST_DATA_HI;
      ST_CHECK:   if (w_xfer) w_state_nxt = w_csum_ok ? ST_DONE : ST_ERR;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkn or negedge rstn) begin
    if (!rstn) begin
      r_addr_hi   <= '0;
      r_cnt_hi    <= '0;
      r_data_hi   <= '0;
      r_csum      <= '0;
      r_ptr       <= '0;
      r_mem_adr   <= '0;
      r_remaining <= '0;
      r_mem_data  <= '0;
      r_words     <= '0;
      r_we        <= 1'b0;
      r_sel       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_state == ST_WRITE) begin
        r_ptr       <= r_ptr + 1'b1;
        r_words     <= r_words + 1'b1;
        r_remaining <= r_remaining - 16'd1;
      end
      if (w_xfer) begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (w_is_sync) begin
              r_done  <= 1'b0;
              r_err   <= 1'b0;
              r_words <= '0;
              r_csum  <= '0;
              r_sel   <= 1'b1;
            end
          end
          ST_ADDR_HI: begin
            r_addr_hi <= rx_data;
            r_csum    <= r_csum ^ rx_data;
          end
          ST_ADDR_LO: begin
            r_ptr  <= ADDR_W'({r_addr_hi, rx_data});
            r_csum <= r_csum ^ rx_data;
          end
          ST_CNT_HI: begin
            r_cnt_hi <= rx_data;
            r_csum   <= r_csum ^ rx_data;
          end
          ST_CNT_LO: begin
            r_remaining <= {r_cnt_hi, rx_data};
            r_csum      <= r_csum ^ rx_data;
            if (!w_cnt_zero && w_cnt_big) r_err <= 1'b1;
          end
          ST_DATA_HI: begin
            r_data_hi <= rx_data;
            r_csum    <= r_csum ^ rx_data;
          end
          ST_DATA_LO: begin
            // Address/data latched here so they stay put after the strobe.
            r_mem_data <= {r_data_hi, rx_data};
            r_mem_adr  <= r_ptr;
            r_we       <= 1'b1;
            r_csum     <= r_csum ^ rx_data;
          end
          ST_CHECK: begin
            if (w_csum_ok) begin
              r_done <= 1'b1;
              r_sel  <= 1'b0;
            end else begin
              r_err  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_sel       = r_sel;
  assign mem_we        = r_we;
  assign mem_adr       = r_mem_adr;
  assign mem_data      = r_mem_data;
  assign load_done     = r_done;
  assign load_err      = r_err;
  assign words_written = r_words;

endmodule
`default_nettype wire

// File: tb/tb_cnn16_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn16_prog_loader
// Purpose  : Self-checking bench for the CNN-16 program loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn16_prog_loader;

  localparam int ADDR_W = 12;

  logic              clkn = 1'b0;
  logic              rstn = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready, mem_sel, mem_we, load_done, load_err;
  logic [ADDR_W-1:0] mem_adr;
  logic [15:0]       mem_data;
  logic [ADDR_W:0]   words_written;

  cnn16_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clkn(clkn), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_sel(mem_sel), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_data(mem_data), .load_done(load_done), .load_err(load_err),
    .words_written(words_written)
  );

  always #5 clkn = ~clkn;

  typedef struct { logic [11:0] adr; logic [15:0] data; } wr_t;

  int          tests = 0;
  int          fails = 0;
  wr_t         exp_q[$];
  logic [15:0] wq[$];
  logic [15:0] dut_ram [0:4095];
  int          ready_low_cnt = 0;
  int          we_cnt = 0;
  logic [7:0]  model_csum;
  int          byte_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every cycle: writes must match the expected write order, flags never both set.
  always @(negedge clkn) begin
    if (rstn) begin
      wr_t w;
      if (!rx_ready) ready_low_cnt++;
      check("done_err_exclusive", 32'(load_done & load_err), 0);
      if (mem_we) begin
        we_cnt++;
        check("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("write_adr", 32'(mem_adr), 32'(w.adr));
          check("write_data", 32'(mem_data), 32'(w.data));
        end
        dut_ram[mem_adr] = mem_data;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clkn);
      rx_valid = 1'b0;
      rx_data  = ~b;
    end
    @(negedge clkn);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    forever begin
      ok = rx_ready;
      @(posedge clkn);
      if (ok) break;
      n++;
      if (n > 20) begin
        tests++;
        fails++;
        $display("FAIL handshake_timeout: rx_ready low for %0d cycles, required at most 1", n);
        break;
      end
      @(negedge clkn);
    end
    byte_idx++;
  endtask

  function automatic int gap_for(input int mode);
    return (mode != 0) ? (byte_idx * 5 + 1) % 4 : 0;
  endfunction

  // Model: frame bytes, expected writes and outcome derived from the frame rules.
  task automatic run_frame(input logic [15:0] addr, input logic [15:0] cnt,
                           input logic [7:0] csum_flip, input int gapmode);
    logic [7:0]  bytes[$];
    logic [11:0] a;
    bit          over, good;
    a    = addr[11:0];
    over = (32'(cnt) > 4096);
    bytes.push_back(addr[15:8]);
    bytes.push_back(addr[7:0]);
    bytes.push_back(cnt[15:8]);
    bytes.push_back(cnt[7:0]);
    if (!over) begin
      for (int i = 0; i < int'(cnt); i++) begin
        bytes.push_back(wq[i][15:8]);
        bytes.push_back(wq[i][7:0]);
        exp_q.push_back('{adr: a + 12'(i), data: wq[i]});
      end
    end
    model_csum = 8'h00;
    foreach (bytes[i]) model_csum = model_csum ^ bytes[i];
    if (!over) bytes.push_back(model_csum ^ csum_flip);
    good = !over && (csum_flip == 8'h00);

    ready_low_cnt = 0;
    send_byte(8'hA5, gap_for(gapmode));
    foreach (bytes[i]) send_byte(bytes[i], gap_for(gapmode));
    @(negedge clkn);
    rx_valid = 1'b0;
    repeat (3) @(negedge clkn);

    check("frame_done", 32'(load_done), 32'(good));
    check("frame_err", 32'(load_err), 32'(!good));
    check("frame_sel", 32'(mem_sel), 32'(!good));
    check("frame_words", 32'(words_written), over ? 0 : 32'(cnt));
    check("frame_writes_left", 32'(exp_q.size()), 0);
    check("frame_ready_low", 32'(ready_low_cnt), over ? 0 : 32'(cnt));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 1);
    check({tag, "_mem_sel"}, 32'(mem_sel), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_adr"}, 32'(mem_adr), 0);
    check({tag, "_mem_data"}, 32'(mem_data), 0);
    check({tag, "_load_done"}, 32'(load_done), 0);
    check({tag, "_load_err"}, 32'(load_err), 0);
    check({tag, "_words"}, 32'(words_written), 0);
  endtask

  initial begin
    int we_before;
    repeat (3) @(negedge clkn);
    check_reset_values("reset");
    rstn = 1'b1;

    // Basic frame.
    wq.delete(); wq.push_back(16'h1234); wq.push_back(16'hABCD); wq.push_back(16'h0F0F);
    run_frame(16'h0010, 16'd3, 8'h00, 0);
    check("lit_csum_basic", 32'(model_csum), 32'h53);
    check("lit_ram_010", 32'(dut_ram[12'h010]), 32'h1234);
    check("lit_ram_011", 32'(dut_ram[12'h011]), 32'hABCD);
    check("lit_ram_012", 32'(dut_ram[12'h012]), 32'h0F0F);
    check("lit_done_basic", 32'(load_done), 1);

    // Same frame, corrupted checksum, then a good frame clears the error.
    run_frame(16'h0010, 16'd3, 8'hFF, 0);
    check("lit_err_badcsum", 32'(load_err), 1);
    check("lit_sel_badcsum", 32'(mem_sel), 1);
    wq.delete(); wq.push_back(16'h5A5A); wq.push_back(16'h0001);
    run_frame(16'h0200, 16'd2, 8'h00, 0);

    // Address wrap, upper address bits ignored.
    wq.delete(); wq.push_back(16'hBEEF); wq.push_back(16'hCAFE);
    run_frame(16'hF0FF | 16'h0F00, 16'd2, 8'h00, 0);
    check("lit_ram_fff", 32'(dut_ram[12'hFFF]), 32'hBEEF);
    check("lit_ram_000", 32'(dut_ram[12'h000]), 32'hCAFE);

    // Zero-length frame and oversize count.
    we_before = we_cnt;
    wq.delete();
    run_frame(16'h0FFF, 16'd0, 8'h00, 0);
    check("lit_csum_zero", 32'(model_csum), 32'hF0);
    check("zero_cnt_no_we", 32'(we_cnt - we_before), 0);
    run_frame(16'h0000, 16'h1001, 8'h00, 0);
    check("lit_err_bigcnt", 32'(load_err), 1);

    // Idle noise, rx_valid gaps, sync-valued data bytes.
    send_byte(8'h3C, 0);
    send_byte(8'h00, 2);
    wq.delete(); wq.push_back(16'hA5A5); wq.push_back(16'h00A5);
    wq.push_back(16'h7E81); wq.push_back(16'hFFFF);
    run_frame(16'h0123, 16'd4, 8'h00, 1);
    check("lit_ram_123", 32'(dut_ram[12'h123]), 32'hA5A5);
    check("lit_ram_126", 32'(dut_ram[12'h126]), 32'hFFFF);

    // Reset while the second word of a five-word frame is being written.
    exp_q.push_back('{adr: 12'h300, data: 16'h1111});
    exp_q.push_back('{adr: 12'h301, data: 16'h2222});
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h05, 0);
    send_byte(8'h11, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h22, 0);
    @(negedge clkn);
    rx_valid = 1'b0;
    check("mid_we_before_reset", 32'(mem_we), 1);
    #2 rstn = 1'b0;
    #1 check_reset_values("midreset");
    check("midreset_writes_left", 32'(exp_q.size()), 0);
    @(negedge clkn);
    rstn = 1'b1;
    wq.delete(); wq.push_back(16'h3333); wq.push_back(16'h4444);
    run_frame(16'h0300, 16'd2, 8'h00, 0);
    check("lit_ram_300_after", 32'(dut_ram[12'h300]), 32'h3333);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
